// File: rtl/tx_frame_piso.sv
// -----------------------------------------------------------------------------
// tx_frame_piso
//   UART transmit framer and parallel-in/serial-out shifter. One bit leaves on
//   DataOut per BaudOut cycle. A Send request in IDLE latches DataIn onto
//   RegOut. RegOut feeds an external parity unit. That unit's ParityOut is
//   sampled back at the end of the data bits. The serial frame is:
//   start(0), data LSB-first, optional parity, stop(1) [, second stop(1)].
//
// Optional feature macro: UART_TX_TWO_STOP_EN
//   defined   : StopBits port present; STOP2 state reachable (two stop bits).
//   undefined : StopBits port and STOP2 removed; always one stop bit.
//
// Parameters
//   DATA_WIDTH  data bits per frame, 5..8; RegOut is zero-extended above it.
//
// Ports
//   BaudOut     in   clock, one rising edge per bit time
//   ResetN      in   asynchronous active-low reset
//   DataIn      in   parallel data, sampled when Send is accepted
//   Send        in   frame request level, sampled only in IDLE
//   ParityType  in   00/11 none, 01 odd, 10 even (captured per frame)
//   ParityOut   in   parity bit computed externally from RegOut
//   StopBits    in   0 = one stop bit, 1 = two (UART_TX_TWO_STOP_EN only)
//   RegOut      out  latched frame data for the parity unit
//   DataOut     out  serial TX line, idle high
//   Active      out  high from start bit through last stop bit
//   Done        out  one-cycle pulse during the final stop bit
// -----------------------------------------------------------------------------
module tx_frame_piso #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  BaudOut,
  input  logic                  ResetN,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Send,
  input  logic [1:0]            ParityType,
  input  logic                  ParityOut,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                  StopBits,
`endif
  output logic [7:0]            RegOut,
  output logic                  DataOut,
  output logic                  Active,
  output logic                  Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_TWO_STOP_EN
    , S_STOP2
`endif
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(DATA_WIDTH - 1);

  state_e      state_q, state_d;
  logic [7:0]  regout_q, regout_d;
  logic        dout_q, dout_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [2:0]  cnt_q, cnt_d;
  // The 3-bit index cannot represent DATA_WIDTH=8, so the count saturates at
  // the last bit index and this flag marks that the last bit is on the line.
  logic        last_q, last_d;
  logic        par_en_q, par_en_d;
  logic        two_stop;

`ifdef UART_TX_TWO_STOP_EN
  logic        stop2_q, stop2_d;
  assign two_stop = stop2_q;
`else
  assign two_stop = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    regout_d = regout_q;
    dout_d   = dout_q;
    active_d = active_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    last_d   = last_q;
    par_en_d = par_en_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d  = stop2_q;
`endif

    case (state_q)
      S_IDLE: begin
        dout_d   = 1'b1;
        active_d = 1'b0;
        if (Send) begin
          regout_d = 8'(DataIn);
          // 01 and 10 are the only codes that carry a parity slot.
          par_en_d = ^ParityType;
`ifdef UART_TX_TWO_STOP_EN
          stop2_d  = StopBits;
`endif
          dout_d   = 1'b0;
          active_d = 1'b1;
          cnt_d    = '0;
          last_d   = 1'b0;
          state_d  = S_START;
        end
      end

      S_START: begin
        dout_d  = regout_q[0];
        cnt_d   = 3'd1;
        last_d  = 1'b0;
        state_d = S_DATA;
      end

      S_DATA: begin
        if (last_q) begin
          if (par_en_q) begin
            dout_d  = ParityOut;
            state_d = S_PARITY;
          end else begin
            dout_d  = 1'b1;
            done_d  = ~two_stop;
            state_d = S_STOP;
          end
        end else begin
          dout_d = regout_q[cnt_q];
          if (cnt_q == LAST_IDX) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        dout_d  = 1'b1;
        done_d  = ~two_stop;
        state_d = S_STOP;
      end

      S_STOP: begin
        dout_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        if (two_stop) begin
          done_d  = 1'b1;
          state_d = S_STOP2;
        end else begin
          active_d = 1'b0;
          state_d  = S_IDLE;
        end
`else
        active_d = 1'b0;
        state_d  = S_IDLE;
`endif
      end

`ifdef UART_TX_TWO_STOP_EN
      S_STOP2: begin
        dout_d   = 1'b1;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
`endif

      default: begin
        dout_d   = 1'b1;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge BaudOut or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= S_IDLE;
      regout_q <= '0;
      dout_q   <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      par_en_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      regout_q <= regout_d;
      dout_q   <= dout_d;
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      par_en_q <= par_en_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q  <= stop2_d;
`endif
    end
  end

  assign RegOut  = regout_q;
  assign DataOut = dout_q;
  assign Active  = active_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_tx_frame_piso.sv
module tb_tx_frame_piso;

  logic       BaudOut = 1'b0;
  logic       ResetN;
  logic [7:0] DataIn;
  logic       Send;
  logic [1:0] ParityType;
  logic       ParityOut;
  logic [7:0] RegOut;
  logic       DataOut, Active, Done;
  logic       par_odd;
`ifdef UART_TX_TWO_STOP_EN
  logic       StopBits;
`endif

  logic [4:0] DataIn5;
  logic       Send5;
  logic [1:0] ParityType5;
  logic       ParityOut5;
  logic [7:0] RegOut5;
  logic       DataOut5, Active5, Done5;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  always #5 BaudOut = ~BaudOut;

  // Behavioural parity unit, a pure function of RegOut.
  assign ParityOut  = par_odd ? ~^RegOut : ^RegOut;
  assign ParityOut5 = ~^RegOut5;

  tx_frame_piso #(.DATA_WIDTH(8)) u_dut (
    .BaudOut   (BaudOut),
    .ResetN    (ResetN),
    .DataIn    (DataIn),
    .Send      (Send),
    .ParityType(ParityType),
    .ParityOut (ParityOut),
`ifdef UART_TX_TWO_STOP_EN
    .StopBits  (StopBits),
`endif
    .RegOut    (RegOut),
    .DataOut   (DataOut),
    .Active    (Active),
    .Done      (Done)
  );

  tx_frame_piso #(.DATA_WIDTH(5)) u_dut5 (
    .BaudOut   (BaudOut),
    .ResetN    (ResetN),
    .DataIn    (DataIn5),
    .Send      (Send5),
    .ParityType(ParityType5),
    .ParityOut (ParityOut5),
`ifdef UART_TX_TWO_STOP_EN
    .StopBits  (1'b0),
`endif
    .RegOut    (RegOut5),
    .DataOut   (DataOut5),
    .Active    (Active5),
    .Done      (Done5)
  );

  // Expected per-cycle {DataOut, Done} for one 8-bit frame.
  task automatic push_frame(input logic [7:0] d, input logic [1:0] pt, input logic s2);
    exp_q.push_back(2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b0});
    if (pt == 2'b01) exp_q.push_back({~^d, 1'b0});
    if (pt == 2'b10) exp_q.push_back({^d, 1'b0});
    if (s2) begin
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b11);
    end else begin
      exp_q.push_back(2'b11);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic s2);
    @(posedge BaudOut); #1;
    DataIn = d; ParityType = pt; par_odd = (pt == 2'b01); Send = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
    StopBits = s2;
`endif
    push_frame(d, pt, s2);
    @(posedge BaudOut); #1;
    Send = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while ((Active !== 1'b0 || exp_q.size() != 0) && n < 100) begin
      @(negedge BaudOut);
      n++;
    end
    checks++;
    assert (Active === 1'b0 && exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: active=%b pending=%0d, want active=0 pending=0", tag, Active, exp_q.size());
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Scoreboard monitor: every active cycle consumes one expected bit.
  always @(negedge BaudOut) begin
    if (ResetN === 1'b1) begin
      if (Active === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_bit: DataOut=%b Done=%b with no frame pending, want idle", DataOut, Done);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          checks++;
          assert ({DataOut, Done} === mon_exp) else begin
            errors++;
            $error("FAIL frame_bit: {DataOut,Done}=%b want %b (remaining %0d)", {DataOut, Done}, mon_exp, exp_q.size());
          end
        end
      end else begin
        checks++;
        assert (DataOut === 1'b1 && Done === 1'b0) else begin
          errors++;
          $error("FAIL idle_line: DataOut=%b Done=%b want 1 0", DataOut, Done);
        end
      end
    end
  end

  initial begin
    int unsigned n;
    int unsigned idle;
    logic [4:0] d5;
    logic       b;

    ResetN = 1'b0; DataIn = '0; Send = 1'b0; ParityType = 2'b00; par_odd = 1'b0;
    DataIn5 = '0; Send5 = 1'b0; ParityType5 = 2'b01;
`ifdef UART_TX_TWO_STOP_EN
    StopBits = 1'b0;
`endif
    repeat (3) @(negedge BaudOut);
    check8("reset_regout", RegOut, 8'h00);
    check8("reset_line", {5'b0, DataOut, Active, Done}, 8'b0000_0100);
    #2 ResetN = 1'b1;
    repeat (3) @(negedge BaudOut);

    // Odd parity, 0xA5
    send(8'hA5, 2'b01, 1'b0);
    wait_idle("frame_a5_odd");
    check8("regout_hold_a5", RegOut, 8'hA5);

    // Even parity, 0x07
    send(8'h07, 2'b10, 1'b0);
    wait_idle("frame_07_even");

    // No parity, both codes
    send(8'hFF, 2'b00, 1'b0);
    wait_idle("frame_ff_pt00");
    send(8'hFF, 2'b11, 1'b0);
    wait_idle("frame_ff_pt11");

    // Mid-frame Send and input changes ignored
    send(8'h96, 2'b01, 1'b0);
    repeat (3) @(negedge BaudOut);
    #1 Send = 1'b1; DataIn = 8'h00; ParityType = 2'b00;
    repeat (2) @(negedge BaudOut);
    #1 Send = 1'b0;
    wait_idle("frame_96_midsend");
    repeat (4) @(negedge BaudOut);
    check8("no_second_frame", {7'b0, Active}, 8'h00);
    check8("regout_hold_96", RegOut, 8'h96);

    // Send held high: back-to-back frames with one idle cycle
    @(posedge BaudOut); #1;
    DataIn = 8'h5A; ParityType = 2'b10; par_odd = 1'b0; Send = 1'b1;
    push_frame(8'h5A, 2'b10, 1'b0);
    push_frame(8'h5A, 2'b10, 1'b0);
    @(posedge BaudOut); #1;
    n = 0;
    do begin
      @(negedge BaudOut);
      n++;
    end while (Active !== 1'b0 && n < 40);
    idle = 0;
    while (Active === 1'b0 && idle < 40) begin
      idle++;
      @(negedge BaudOut);
    end
    check8("held_idle_gap", 8'(idle), 8'd1);
    #1 Send = 1'b0;
    wait_idle("frame_5a_held");

    // Async reset during data bit 4
    send(8'h3C, 2'b00, 1'b0);
    repeat (6) @(negedge BaudOut);
    #2 ResetN = 1'b0;
    #1;
    check8("rst_mid_line", {6'b0, DataOut, Active}, 8'b0000_0010);
    check8("rst_mid_regout", RegOut, 8'h00);
    check8("rst_mid_done", {7'b0, Done}, 8'h00);
    exp_q.delete();
    @(negedge BaudOut);
    #2 ResetN = 1'b1;
    repeat (6) @(negedge BaudOut);
    check8("post_rst_idle", {6'b0, DataOut, Active}, 8'b0000_0010);
    check8("post_rst_regout", RegOut, 8'h00);

    // Narrow build: 5 data bits, odd parity
    d5 = 5'b10110;
    @(posedge BaudOut); #1 DataIn5 = d5; Send5 = 1'b1;
    @(posedge BaudOut); #1 Send5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge BaudOut);
      if (i == 0)      b = 1'b0;
      else if (i <= 5) b = d5[i-1];
      else if (i == 6) b = ~^d5;
      else             b = 1'b1;
      check8($sformatf("w5_bit%0d", i), {6'b0, DataOut5, Done5}, {6'b0, b, (i == 7)});
    end
    @(negedge BaudOut);
    check8("w5_end_active", {7'b0, Active5}, 8'h00);
    check8("w5_regout", RegOut5, 8'h16);

`ifdef UART_TX_TWO_STOP_EN
    // Two stop bits, odd parity
    send(8'h3C, 2'b01, 1'b1);
    wait_idle("frame_3c_two_stop");
    send(8'hC3, 2'b00, 1'b0);
    wait_idle("frame_c3_one_stop");
`endif

    repeat (3) @(negedge BaudOut);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
